// File: rtl/mdl_z14gen_pkg.sv
// Shared definitions for the Z14 check-word generator and its LFSR.
package mdl_z14gen_pkg;

  localparam int CRC_BITS = 14;

  // x^14 + x^5 + x^4 + 1, feedback taps at bits 0, 4 and 5
  localparam logic [CRC_BITS-1:0] CRC_POLY = 14'h0031;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } gen_state_t;

endpackage

// File: rtl/mdl_crc14_lfsr.sv
// CRC14 remainder register. With feedback enabled it divides the serial
// input by the polynomial; with feedback disabled it is a plain left shift
// that walks the remainder out MSB-first. The evaluator uses the same layout.
module mdl_crc14_lfsr
  import mdl_z14gen_pkg::*;
(
  input  logic                i_MCLK,
  input  logic                ce,
  input  logic                clear,
  input  logic                shift,
  input  logic                fb_en,
  input  logic                din,
  output logic [CRC_BITS-1:0] crc
);

  logic                fb;
  logic [CRC_BITS-1:0] crc_nxt;

  // Next remainder: shift left and fold in the polynomial when feedback is set
  always_comb begin
    fb      = fb_en & (crc[CRC_BITS-1] ^ din);
    crc_nxt = {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  end

  // Remainder register; clear wins over shift, nothing moves without ce
  always_ff @(posedge i_MCLK) begin
    if (ce) begin
      if (clear)      crc <= '0;
      else if (shift) crc <= crc_nxt;
    end
  end

endmodule

// File: rtl/mdl_z14gen.sv
// CRC14 check-word generator: passes a page of serial data through and then
// appends the 14-bit remainder MSB-first so the evaluator reads back zero.
module mdl_z14gen
  import mdl_z14gen_pkg::*;
#(
  parameter int PAGE_BITS = 512
) (
  input  logic                i_MCLK,
  input  logic                i_SYS_RST_n,
  input  logic                i_CLK2M_PCEN_n,
  input  logic                i_GEN_START_n,
  input  logic                i_GEN_ABORT_n,
  input  logic                i_BIT_STB,
  input  logic                i_GEN_BDI,
  output logic                o_GEN_BDO,
  output logic                o_GEN_BUSY_n,
  output logic                o_GEN_DONE_n,
  output logic [CRC_BITS-1:0] o_CRC14
);

  localparam logic [11:0] LAST_DATA = 12'(PAGE_BITS - 1);
  localparam logic [11:0] LAST_CRC  = 12'(CRC_BITS - 1);

  gen_state_t          state, state_nxt;
  logic [11:0]         cnt;
  logic                en;
  logic                rst;
  logic                abort;
  logic                in_phase;
  logic                lfsr_clr;
  logic [CRC_BITS-1:0] crc;

  assign en       = ~i_CLK2M_PCEN_n;
  assign rst      = ~i_SYS_RST_n;
  assign abort    = ~i_GEN_ABORT_n;
  assign in_phase = (state == DATA) || (state == CRC);

  // The register is wiped by reset, abort, or a start accepted in IDLE
  assign lfsr_clr = rst | abort | ((state == IDLE) & ~i_GEN_START_n);

  mdl_crc14_lfsr u_lfsr (
    .i_MCLK (i_MCLK),
    .ce     (en),
    .clear  (lfsr_clr),
    .shift  (i_BIT_STB & in_phase),
    .fb_en  (state == DATA),
    .din    (i_GEN_BDI),
    .crc    (crc)
  );

  // State register, advanced only on enabled edges
  always_ff @(posedge i_MCLK) begin
    if (en) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides start and strobe
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!i_GEN_START_n)                 state_nxt = DATA;
        DATA:    if (i_BIT_STB && cnt == LAST_DATA)  state_nxt = CRC;
        CRC:     if (i_BIT_STB && cnt == LAST_CRC)   state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bit counter: restarts at every phase change, counts strobes inside a phase
  always_ff @(posedge i_MCLK) begin
    if (en) begin
      if (rst || abort || state_nxt != state) cnt <= '0;
      else if (i_BIT_STB && in_phase)         cnt <= cnt + 12'd1;
    end
  end

  // Outputs decoded from the current state; data passes straight through
  always_comb begin
    o_GEN_BDO    = 1'b0;
    o_GEN_BUSY_n = ~in_phase;
    o_GEN_DONE_n = (state != DONE);
    case (state)
      DATA:    o_GEN_BDO = i_GEN_BDI;
      CRC:     o_GEN_BDO = crc[CRC_BITS-1];
      default: o_GEN_BDO = 1'b0;
    endcase
  end

  assign o_CRC14 = crc;

endmodule

// File: tb/tb_mdl_z14gen.sv
// Directed bench for mdl_z14gen: an 8-bit-page instance for the short frame
// cases and a 512-bit-page instance for loopback and abort/restart.
module tb_mdl_z14gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pcen_n, start_n, abort_n, stb, bdi;
  logic bdo_s, busy_s, done_s;
  logic [13:0] crc_s;
  logic bdo_l, busy_l, done_l;
  logic [13:0] crc_l;

  int n_cmp  = 0;
  int n_fail = 0;

  mdl_z14gen #(.PAGE_BITS(8)) u_dut (
    .i_MCLK(clk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n),
    .i_GEN_START_n(start_n), .i_GEN_ABORT_n(abort_n), .i_BIT_STB(stb),
    .i_GEN_BDI(bdi), .o_GEN_BDO(bdo_s), .o_GEN_BUSY_n(busy_s),
    .o_GEN_DONE_n(done_s), .o_CRC14(crc_s)
  );

  mdl_z14gen #(.PAGE_BITS(512)) u_dut_pg (
    .i_MCLK(clk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n),
    .i_GEN_START_n(start_n), .i_GEN_ABORT_n(abort_n), .i_BIT_STB(stb),
    .i_GEN_BDI(bdi), .o_GEN_BDO(bdo_l), .o_GEN_BUSY_n(busy_l),
    .o_GEN_DONE_n(done_l), .o_CRC14(crc_l)
  );

  typedef struct {
    logic        start_n;
    logic        stb;
    logic        bdi;
    logic        exp_bdo;
    logic        exp_busy_n;
    logic        exp_done_n;
    logic [13:0] exp_crc;
  } vec_t;

  vec_t tbl [25];

  // Remainder sequence while the check word 0x0031 is shifted out
  logic [13:0] crc_seq [14] = '{
    14'h0031, 14'h0062, 14'h00C4, 14'h0188, 14'h0310, 14'h0620, 14'h0C40,
    14'h1880, 14'h3100, 14'h2200, 14'h0400, 14'h0800, 14'h1000, 14'h2000
  };
  // Serial check bits 00000000110001, MSB first
  logic crc_bits [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic data_bits [512];
  logic out_bits  [526];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic abort_all();
    start_n = 1'b1; stb = 1'b0; abort_n = 1'b0;
    tick();
    abort_n = 1'b1;
  endtask

  // Behavioural evaluator step, written directly from the bit equation
  function automatic logic [13:0] eval_step(input logic [13:0] r, input logic b);
    logic fb;
    fb = r[13] ^ b;
    return {r[12:5], r[4] ^ fb, r[3] ^ fb, r[2:0], fb};
  endfunction

  function automatic logic [13:0] eval_frame(input int flip);
    logic [13:0] r;
    r = '0;
    for (int i = 0; i < 526; i++) r = eval_step(r, out_bits[i] ^ (i == flip));
    return r;
  endfunction

  initial begin
    int busy_cnt, done_cnt, ones_cnt, pass_err, mid_cnt;
    logic [13:0] model_r, held_crc;

    rst_n = 1'b0; pcen_n = 1'b0; start_n = 1'b1; abort_n = 1'b1; stb = 1'b0; bdi = 1'b0;
    tick(); tick();

    // Reset values
    #1;
    chk("rst_bdo", bdo_s, 0);
    chk("rst_busy_n", busy_s, 1);
    chk("rst_done_n", done_s, 1);
    chk("rst_crc", crc_s, 0);
    chk("rst_crc_pg", crc_l, 0);
    rst_n = 1'b1;
    tick();

    // Single 1 as last data bit: table of per-cycle expectations
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h0000};
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = '{1'b1, 1'b1, logic'(i == 8), logic'(i == 8), 1'b0, 1'b1, 14'h0000};
    end
    for (int k = 0; k < 14; k++) begin
      tbl[9 + k] = '{1'b1, 1'b1, 1'b1, crc_bits[k], 1'b0, 1'b1, crc_seq[k]};
    end
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0000};
    tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0000};

    for (int i = 0; i < 25; i++) begin
      start_n = tbl[i].start_n; stb = tbl[i].stb; bdi = tbl[i].bdi;
      #1;
      chk($sformatf("tbl%0d_bdo", i),    bdo_s,  tbl[i].exp_bdo);
      chk($sformatf("tbl%0d_busy_n", i), busy_s, tbl[i].exp_busy_n);
      chk($sformatf("tbl%0d_done_n", i), done_s, tbl[i].exp_done_n);
      chk($sformatf("tbl%0d_crc", i),    crc_s,  tbl[i].exp_crc);
      tick();
    end
    abort_all();
    tick();

    // All-zero page: 22 busy strobes, one done cycle, all output bits zero
    start_n = 1'b0; stb = 1'b0; bdi = 1'b0;
    tick();
    busy_cnt = 0; done_cnt = 0; ones_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      start_n = 1'b1; stb = 1'b1; bdi = 1'b0;
      #1;
      if (!busy_s) busy_cnt++;
      if (!done_s) done_cnt++;
      if (bdo_s)   ones_cnt++;
      tick();
    end
    chk("zero_busy_strobes", busy_cnt, 22);
    chk("zero_done_cycles", done_cnt, 1);
    chk("zero_bdo_ones", ones_cnt, 0);
    chk("zero_final_crc", crc_s, 0);
    abort_all();
    tick();

    // Start held low through the page, with a strobe on the start cycle
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      start_n = (done_cnt > 0); stb = 1'b1; bdi = 1'b1;
      #1;
      if (!busy_s) busy_cnt++;
      if (!done_s) done_cnt++;
      tick();
    end
    chk("held_start_busy_strobes", busy_cnt, 22);
    chk("held_start_done_cycles", done_cnt, 1);
    abort_all();
    tick();

    // Loopback of a random 512-bit page through the evaluator model
    model_r = '0;
    for (int i = 0; i < 512; i++) begin
      data_bits[i] = logic'($urandom_range(0, 1));
      model_r = eval_step(model_r, data_bits[i]);
    end
    start_n = 1'b0; stb = 1'b0;
    tick();
    pass_err = 0;
    for (int n = 0; n < 526; n++) begin
      start_n = 1'b1; stb = 1'b1; bdi = (n < 512) ? data_bits[n] : 1'b0;
      #1;
      out_bits[n] = bdo_l;
      if (n < 512 && bdo_l !== data_bits[n]) pass_err++;
      if (n == 512) chk("loop_remainder_after_data", crc_l, model_r);
      tick();
    end
    stb = 1'b0;
    #1;
    chk("loop_passthrough_errors", pass_err, 0);
    chk("loop_done_n", done_l, 0);
    chk("loop_eval_remainder", eval_frame(-1), 0);
    chk("loop_flip0_nonzero", (eval_frame(0) != 14'h0), 1);
    chk("loop_flip300_nonzero", (eval_frame(300) != 14'h0), 1);
    chk("loop_flip520_nonzero", (eval_frame(520) != 14'h0), 1);
    tick();
    abort_all();
    tick();

    // Abort at data bit 100, then immediate restart of a full frame
    start_n = 1'b0; stb = 1'b0;
    tick();
    for (int n = 0; n < 100; n++) begin
      start_n = 1'b1; stb = 1'b1; bdi = logic'(n % 3 == 0);
      tick();
    end
    abort_n = 1'b0; stb = 1'b1; bdi = 1'b1;
    tick();
    abort_n = 1'b1; stb = 1'b0;
    #1;
    chk("abort_busy_n", busy_l, 1);
    chk("abort_done_n", done_l, 1);
    chk("abort_crc", crc_l, 0);
    start_n = 1'b0;
    tick();
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 600 && done_cnt == 0; c++) begin
      start_n = 1'b1; stb = 1'b1; bdi = logic'(c % 5 == 1);
      #1;
      if (!busy_l) busy_cnt++;
      if (!done_l) done_cnt++;
      tick();
    end
    chk("restart_frame_strobes", busy_cnt, 526);
    chk("restart_done_seen", done_cnt, 1);
    abort_all();
    tick();

    // Reset during CRC bit 5 with the clock enable pulsing
    start_n = 1'b0; stb = 1'b0;
    tick();
    for (int n = 0; n < 13; n++) begin
      start_n = 1'b1; stb = 1'b1; bdi = 1'b1;
      tick();
    end
    #1;
    held_crc = crc_s;
    chk("mid_crc_busy_n", busy_s, 0);
    pcen_n = 1'b1; rst_n = 1'b0; stb = 1'b1;
    tick();
    chk("rst_disabled_busy_n", busy_s, 0);
    chk("rst_disabled_crc", crc_s, held_crc);
    pcen_n = 1'b0;
    tick();
    chk("rst_enabled_busy_n", busy_s, 1);
    chk("rst_enabled_done_n", done_s, 1);
    chk("rst_enabled_bdo", bdo_s, 0);
    chk("rst_enabled_crc", crc_s, 0);
    rst_n = 1'b1;
    mid_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      pcen_n = logic'(c % 2); stb = 1'b1;
      #1;
      if (!done_s || !busy_s) mid_cnt++;
      tick();
    end
    chk("post_rst_no_done_or_busy", mid_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
